frame_dispatcher: RTL and testbench

- Sequences instruction-frame delivery from the scheduler's frame memory to the 16 cores over one shared 16-bit bus.
- Takes one pending frame and picks an eligible, ready core round-robin.
- Streams the frame's FRAME_WORDS words to that core with a per-word handshake, then marks the core pending until it leaves ready.
- Sits between the scheduler frame store (read port) and the core bus.

---
 rtl/frame_disp_pkg.sv | 28 ++
 rtl/frame_dispatcher_rr_pick.sv | 38 +++
 rtl/frame_dispatcher.sv | 151 +++++++++++++++
 tb/tb_frame_dispatcher.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_disp_pkg.sv
// ---------------------------------------------------------------------------
// frame_disp_pkg
//   Shared constants, FSM state type and helpers for the frame dispatcher.
//   CORE_NUM cores share one INSTR_SIZE-bit bus; each frame is FRAME_WORDS
//   words long and FRAME_NUM frames live in the scheduler frame store.
// ---------------------------------------------------------------------------
package frame_disp_pkg;

  localparam int CORE_NUM    = 16;
  localparam int INSTR_SIZE  = 16;
  localparam int FRAME_WORDS = 16;
  localparam int FRAME_NUM   = 64;
  localparam int FRAME_AW    = $clog2(FRAME_NUM);
  localparam int WCNT_W      = $clog2(FRAME_WORDS);
  localparam int GIDX_W      = $clog2(CORE_NUM);
  localparam int RD_AW       = FRAME_AW + WCNT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

  function automatic logic [CORE_NUM-1:0] onehot(input logic [GIDX_W-1:0] idx);
    onehot = CORE_NUM'(1) << idx;
  endfunction

endpackage

// File: rtl/frame_dispatcher_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Returns the first set bit of
//   eligible_i strictly after rr_ptr_i, wrapping modulo CORE_NUM; rr_ptr_i
//   itself is the last candidate considered.
// Ports:
//   eligible_i  cores that may take the frame
//   rr_ptr_i    index of the most recently granted core
//   gidx_o      chosen core index (0 when any_o is low)
//   any_o       at least one core is eligible
// ---------------------------------------------------------------------------
module rr_pick
  import frame_disp_pkg::*;
(
  input  logic [CORE_NUM-1:0] eligible_i,
  input  logic [GIDX_W-1:0]   rr_ptr_i,
  output logic [GIDX_W-1:0]   gidx_o,
  output logic                any_o
);

  always_comb begin
    logic [GIDX_W-1:0] idx;
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    idx    = '0;
    gidx_o = '0;
    any_o  = 1'b0;
    // Offset k=CORE_NUM truncates to 0, so rr_ptr_i is checked last.
    for (int k = 1; k <= CORE_NUM; k++) begin
      idx = rr_ptr_i + GIDX_W'(k);
      if (!any_o && eligible_i[idx]) begin
        any_o  = 1'b1;
        gidx_o = idx;
      end
    end
  end

endmodule

// File: rtl/frame_dispatcher.sv
// ---------------------------------------------------------------------------
// frame_dispatcher
//   Takes one pending frame from the scheduler, grants it round-robin to an
//   eligible ready core and streams its FRAME_WORDS words over the shared
//   bus with a per-word handshake. A served core is marked pending until it
//   drops core_ready, so it is not handed a second frame while still busy.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   frame_valid/idx     upstream frame request and its index
//   core_mask           cores allowed to run the frame
//   frame_take          pulse: request accepted (granted or dropped)
//   mask_err            pulse with frame_take when core_mask is empty
//   core_ready          per-core idle level
//   core_reading        per-core word accept
//   rd_addr / rd_data   combinational frame-store read port
//   bus_data/bus_valid  registered shared bus word
//   core_sel            one-hot target core, 0 when idle
//   frame_being_sent    high while streaming
// ---------------------------------------------------------------------------
module frame_dispatcher
  import frame_disp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_valid,
  input  logic [FRAME_AW-1:0]   frame_idx,
  input  logic [CORE_NUM-1:0]   core_mask,
  output logic                  frame_take,
  output logic                  mask_err,
  input  logic [CORE_NUM-1:0]   core_ready,
  input  logic [CORE_NUM-1:0]   core_reading,
  output logic [RD_AW-1:0]      rd_addr,
  input  logic [INSTR_SIZE-1:0] rd_data,
  output logic [INSTR_SIZE-1:0] bus_data,
  output logic                  bus_valid,
  output logic [CORE_NUM-1:0]   core_sel,
  output logic                  frame_being_sent
);

  state_e                state_q;
  logic [FRAME_AW-1:0]   frame_q;
  logic [GIDX_W-1:0]     gidx_q;
  logic [GIDX_W-1:0]     rr_ptr_q;
  logic [WCNT_W-1:0]     word_cnt_q;
  logic                  last_q;      // bus currently holds the final word
  logic [CORE_NUM-1:0]   pending_q;
  logic [CORE_NUM-1:0]   pending_d;
  logic [INSTR_SIZE-1:0] bus_data_q;
  logic                  bus_valid_q;
  logic [CORE_NUM-1:0]   core_sel_q;
  logic                  sending_q;

  logic [CORE_NUM-1:0]   eligible;
  logic [GIDX_W-1:0]     pick_idx;
  logic                  pick_any;
  logic                  mask_empty;
  logic                  idle_req;
  logic                  xfer;
  logic                  finish;

  assign eligible = core_mask & core_ready & ~pending_q;

  rr_pick u_rr_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .gidx_o     (pick_idx),
    .any_o      (pick_any)
  );

  // The accept handshake is decided in the IDLE cycle itself so that LOAD
  // follows immediately; it is gated by reset so it stays low during reset.
  assign mask_empty = (core_mask == '0);
  assign idle_req   = reset && (state_q == IDLE) && frame_valid;
  assign mask_err   = idle_req && mask_empty;
  assign frame_take = idle_req && (mask_empty || pick_any);

  // Only the granted core's accept counts; other cores' strobes are ignored.
  assign xfer   = bus_valid_q && core_reading[gidx_q];
  assign finish = (state_q == SEND) && xfer && last_q;

  // Clear on not-ready first, then set on completion so set wins a tie.
  always_comb begin
    pending_d = pending_q & core_ready;
    if (finish) pending_d[gidx_q] = 1'b1;
  end

  assign rd_addr          = {frame_q, word_cnt_q};
  assign bus_data         = bus_data_q;
  assign bus_valid        = bus_valid_q;
  assign core_sel         = core_sel_q;
  assign frame_being_sent = sending_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= GIDX_W'(CORE_NUM - 1);
      word_cnt_q  <= '0;
      last_q      <= 1'b0;
      pending_q   <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      core_sel_q  <= '0;
      sending_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (frame_take && pick_any) begin
            frame_q    <= frame_idx;
            gidx_q     <= pick_idx;
            word_cnt_q <= '0;
            last_q     <= 1'b0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          bus_data_q  <= rd_data;
          bus_valid_q <= 1'b1;
          core_sel_q  <= onehot(gidx_q);
          sending_q   <= 1'b1;
          word_cnt_q  <= WCNT_W'(1);
          state_q     <= SEND;
        end
        SEND: begin
          if (xfer) begin
            if (last_q) begin
              bus_valid_q <= 1'b0;
              core_sel_q  <= '0;
              sending_q   <= 1'b0;
              rr_ptr_q    <= gidx_q;
              word_cnt_q  <= '0;
              last_q      <= 1'b0;
              state_q     <= IDLE;
            end else begin
              bus_data_q <= rd_data;
              // Counter parks on the last index instead of wrapping.
              if (word_cnt_q == WCNT_W'(FRAME_WORDS - 1)) last_q <= 1'b1;
              else word_cnt_q <= word_cnt_q + WCNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_frame_dispatcher
//   Self-checking bench for frame_dispatcher: directed scenarios plus a
//   randomized run, checked against a transaction-level reference model
//   (pending set, last-granted pointer, frame memory contents).
// ---------------------------------------------------------------------------
module tb_frame_dispatcher;
  import frame_disp_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  frame_valid;
  logic [FRAME_AW-1:0]   frame_idx;
  logic [CORE_NUM-1:0]   core_mask;
  logic                  frame_take;
  logic                  mask_err;
  logic [CORE_NUM-1:0]   core_ready;
  logic [CORE_NUM-1:0]   core_reading;
  logic [RD_AW-1:0]      rd_addr;
  logic [INSTR_SIZE-1:0] rd_data;
  logic [INSTR_SIZE-1:0] bus_data;
  logic                  bus_valid;
  logic [CORE_NUM-1:0]   core_sel;
  logic                  frame_being_sent;

  logic [INSTR_SIZE-1:0] mem [0:(1<<RD_AW)-1];

  // Reference model state
  logic [CORE_NUM-1:0] mp;       // cores holding a delivered frame
  int                  rr;       // last core granted
  bit                  fin;      // the coming edge completes a frame
  int                  fin_g;

  int n_vec = 0;
  int n_err = 0;

  frame_dispatcher dut (
    .clk              (clk),
    .reset            (reset),
    .frame_valid      (frame_valid),
    .frame_idx        (frame_idx),
    .core_mask        (core_mask),
    .frame_take       (frame_take),
    .mask_err         (mask_err),
    .core_ready       (core_ready),
    .core_reading     (core_reading),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .bus_data         (bus_data),
    .bus_valid        (bus_valid),
    .core_sel         (core_sel),
    .frame_being_sent (frame_being_sent)
  );

  assign rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, updating the pending model with the inputs seen at
  // that edge; returns 1 time unit after the edge.
  task automatic tick();
    if (!reset) begin
      mp  = '0;
      fin = 1'b0;
    end else begin
      mp = mp & core_ready;
      if (fin) begin
        mp[fin_g] = 1'b1;
        fin       = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_pick(input logic [CORE_NUM-1:0] elig, input int last);
    for (int k = 1; k <= CORE_NUM; k++)
      if (elig[(last + k) % CORE_NUM]) return (last + k) % CORE_NUM;
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, bus_valid, 0);
    check({tag, "_sel"}, core_sel, 0);
    check({tag, "_fbs"}, frame_being_sent, 0);
    check({tag, "_take"}, frame_take, 0);
    check({tag, "_merr"}, mask_err, 0);
  endtask

  task automatic do_reset(input int n);
    reset       = 1'b0;
    frame_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b1;
    rr    = CORE_NUM - 1;
    #1;
  endtask

  // Offer one frame in IDLE and, if granted, stream it to completion.
  // stall_at<0 means no stall; g returns the expected core (-1 if dropped).
  task automatic do_frame(input logic [FRAME_AW-1:0] idx, input logic [CORE_NUM-1:0] mask,
                          input int stall_at, input int stall_len, output int g);
    logic [CORE_NUM-1:0] elig;
    logic [RD_AW-1:0]    a;
    frame_valid = 1'b1;
    frame_idx   = idx;
    core_mask   = mask;
    #1;
    g = -1;
    if (mask == '0) begin
      check("empty_take", frame_take, 1);
      check("empty_merr", mask_err, 1);
      check("empty_bus", bus_valid, 0);
      tick();
      frame_valid = 1'b0;
      #1;
      check_quiet("empty_after");
      return;
    end
    elig = mask & core_ready & ~mp;
    g    = ref_pick(elig, rr);
    check("take", frame_take, 1);
    check("take_merr", mask_err, 0);
    tick();                                   // LOAD cycle
    frame_valid         = 1'b0;
    frame_idx           = FRAME_AW'($urandom);
    core_mask           = CORE_NUM'($urandom);
    core_reading        = CORE_NUM'($urandom);
    core_reading[g]     = 1'b1;
    #1;
    check("load_valid", bus_valid, 0);
    check("load_sel", core_sel, 0);
    tick();                                   // first word on the bus
    for (int w = 0; w < FRAME_WORDS; w++) begin
      a = {idx, w[WCNT_W-1:0]};
      if (w == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          core_reading    = CORE_NUM'($urandom);
          core_reading[g] = 1'b0;
          #1;
          check("stall_data", bus_data, mem[a]);
          check("stall_valid", bus_valid, 1);
          tick();
        end
      end
      core_reading    = CORE_NUM'($urandom);
      core_reading[g] = 1'b1;
      #1;
      check("word_data", bus_data, mem[a]);
      check("word_valid", bus_valid, 1);
      check("word_sel", core_sel, CORE_NUM'(1) << g);
      check("word_fbs", frame_being_sent, 1);
      if (w == FRAME_WORDS - 1) begin
        fin   = 1'b1;
        fin_g = g;
      end
      tick();
    end
    core_reading = '0;
    #1;
    check("done_valid", bus_valid, 0);
    check("done_sel", core_sel, 0);
    check("done_fbs", frame_being_sent, 0);
    rr = g;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [CORE_NUM-1:0] m;
    int sa, sl;

    for (int i = 0; i < (1 << RD_AW); i++) mem[i] = INSTR_SIZE'($urandom);
    mp           = '0;
    fin          = 1'b0;
    rr           = CORE_NUM - 1;
    reset        = 1'b0;
    frame_valid  = 1'b1;
    frame_idx    = '0;
    core_mask    = '1;
    core_ready   = '1;
    core_reading = '1;

    // Reset with a request present: nothing may be accepted or driven.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("reset");
    end
    reset       = 1'b1;
    frame_valid = 1'b0;
    #1;

    // Single frame to core 0.
    do_frame(6'd2, 16'h0f0f, -1, 0, g);

    // Core 0 is now pending: a mask of only core 0 must wait.
    frame_valid = 1'b1;
    frame_idx   = 6'd3;
    core_mask   = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pend_no_take", frame_take, 0);
      tick();
    end
    frame_valid = 1'b0;

    // Abort a transfer mid-frame with reset.
    frame_valid = 1'b1;
    frame_idx   = 6'd5;
    core_mask   = 16'hffff;
    #1;
    check("abort_take", frame_take, 1);
    tick();
    frame_valid = 1'b0;
    tick();
    tick();
    tick();
    #1;
    check("abort_busy", bus_valid, 1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("abort_rst");
    end
    reset = 1'b1;
    rr    = CORE_NUM - 1;
    #1;
    check_quiet("abort_idle");
    // Pending on core 0 was cleared by reset even though it stayed ready.
    do_frame(6'd7, 16'h0001, -1, 0, g);

    // Round-robin, all ready: cores 0,1,2.
    do_reset(2);
    for (int f = 0; f < 3; f++) begin
      do_frame(FRAME_AW'(10 + f), 16'h0f0f, -1, 0, g);
      core_ready = '0;
      tick();
      core_ready = '1;
    end

    // Round-robin with core 1 not ready: cores 0,2,3.
    do_reset(2);
    core_ready = 16'hfffd;
    for (int f = 0; f < 3; f++) begin
      do_frame(FRAME_AW'(20 + f), 16'h0f0f, -1, 0, g);
      core_ready = '0;
      tick();
      core_ready = 16'hfffd;
    end
    core_ready = '1;

    // Stall at word 7 for 5 cycles.
    do_frame(6'd33, 16'h0f0f, 7, 5, g);

    // Empty mask.
    do_frame(6'd40, 16'h0000, -1, 0, g);

    // No eligible core until core 4 becomes ready.
    do_reset(1);
    core_ready  = 16'h000f;
    frame_valid = 1'b1;
    frame_idx   = 6'd9;
    core_mask   = 16'h00f0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("noelig_take", frame_take, 0);
      check("noelig_bus", bus_valid, 0);
      tick();
    end
    core_ready = 16'h001f;
    do_frame(6'd9, 16'h00f0, -1, 0, g);
    core_ready = '1;

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      m          = ($urandom_range(0, 5) == 0) ? '0 : CORE_NUM'($urandom);
      core_ready = CORE_NUM'($urandom) | CORE_NUM'($urandom);
      if (m != '0 && (m & core_ready & ~mp) == '0) begin
        core_ready = '0;
        tick();
        core_ready = '1;
      end
      sa = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, FRAME_WORDS - 1));
      sl = int'($urandom_range(0, 4));
      do_frame(FRAME_AW'($urandom), m, sa, sl, g);
      if ($urandom_range(0, 1) == 1) begin
        core_ready = CORE_NUM'($urandom);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
